// File: rtl/nibble_add_sched_if.sv
// Requester, result and status signals of the nibble-serial adder.
// The slave modport is the adder side; the master modport is the requesters/consumer side.
interface nibble_add_sched_if #(
    parameter int unsigned W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id, busy
    );
endinterface

// File: rtl/nibble_add_sched.sv
// Two-requester round-robin adder that reuses a single 4-bit slice, one nibble per cycle.
// The result is held in DONE until the consumer accepts it.
module nibble_add_sched #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_add_sched_if.slave bus
);
    localparam int unsigned   W        = 4 * NIBBLES;
    localparam int unsigned   IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ptr;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
    logic          r_carry;
    logic          r_id;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_res_sum;
    logic          r_res_cout;
    logic          r_res_id;

    logic          w_win;
    logic          w_accept;
    logic          w_last;
    logic [4:0]    w_slice;
    logic [W-1:0]  w_acc_nxt;

    // r_ptr names the requester that wins a tie; 0 after reset
    always_comb begin
        w_win = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_win = r_ptr;
        end else if (bus.req1_valid) begin
            w_win = 1'b1;
        end
    end

    assign w_accept = (r_state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    assign w_last   = (r_idx == LAST_IDX);

    // Operands shift down each ADD cycle so the slice always sees bits [3:0];
    // the sum shifts in from the top and is complete after the last slice.
    assign w_slice   = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
    assign w_acc_nxt = (r_acc >> 4) | (W'(w_slice[3:0]) << (W - 4));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ADD;
            ADD:     if (w_last) w_state_nxt = DONE;
            DONE:    if (bus.res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.res_valid  = (r_state == DONE);
        bus.busy       = (r_state != IDLE);
        if (r_state == IDLE && !rst) begin
            bus.req0_ready = bus.req0_valid && !w_win;
            bus.req1_ready = bus.req1_valid && w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_id       <= 1'b0;
            r_idx      <= '0;
            r_res_sum  <= '0;
            r_res_cout <= 1'b0;
            r_res_id   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_win ? bus.req1_a : bus.req0_a;
                        r_b     <= w_win ? bus.req1_b : bus.req0_b;
                        r_id    <= w_win;
                        r_ptr   <= ~w_win;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                ADD: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_slice[4];
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        r_res_sum  <= w_acc_nxt;
                        r_res_cout <= w_slice[4];
                        r_res_id   <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_sum  = r_res_sum;
    assign bus.res_cout = r_res_cout;
    assign bus.res_id   = r_res_id;
endmodule

// File: tb/tb_nibble_add_sched.sv
// Scoreboard bench: requester drivers push expected results on accept, a monitor pops
// and compares on every result handshake; directed sequences check timing and reset.
`timescale 1ns/1ps
module tb_nibble_add_sched;
    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
    } item_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_res = 0;
    int   rdy0_cnt = 0;
    int   rdy1_cnt = 0;

    item_t q0[$];
    item_t q1[$];
    exp_t  exp_q[$];
    int    gnt_id[$];
    int    gnt_cyc[$];

    nibble_add_sched_if #(.W(W)) bus ();

    nibble_add_sched #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || bus.busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: still busy after %0d cycles, %0d results outstanding", name, budget, exp_q.size());
        end
    endtask

    task automatic wait_res_valid(input string name, input int budget);
        int k = 0;
        while (!bus.res_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_res_valid_seen"}, bus.res_valid, 1);
    endtask

    initial begin : drv0
        item_t it;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        forever begin
            @(negedge clk);
            if (bus.req0_ready) rdy0_cnt++;
            if (bus.req0_valid && bus.req0_ready) begin
                it = q0.pop_front();
                exp_q.push_back('{sum: it.sum, cout: it.cout, id: 1'b0});
                gnt_id.push_back(0);
                gnt_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                bus.req0_valid = 1'b1;
                bus.req0_a     = q0[0].a;
                bus.req0_b     = q0[0].b;
            end else begin
                bus.req0_valid = 1'b0;
            end
        end
    end

    initial begin : drv1
        item_t it;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        forever begin
            @(negedge clk);
            if (bus.req1_ready) rdy1_cnt++;
            if (bus.req1_valid && bus.req1_ready) begin
                it = q1.pop_front();
                exp_q.push_back('{sum: it.sum, cout: it.cout, id: 1'b1});
                gnt_id.push_back(1);
                gnt_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                bus.req1_valid = 1'b1;
                bus.req1_a     = q1[0].a;
                bus.req1_b     = q1[0].b;
            end else begin
                bus.req1_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.res_valid && bus.res_ready) begin
            n_vec++;
            n_res++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected: got sum 0x%0h cout %0d id %0d with nothing expected",
                         bus.res_sum, bus.res_cout, bus.res_id);
            end else begin
                e = exp_q.pop_front();
                if (bus.res_sum !== e.sum || bus.res_cout !== e.cout || bus.res_id !== e.id) begin
                    n_err++;
                    $display("FAIL result: got sum 0x%0h cout %0d id %0d expected sum 0x%0h cout %0d id %0d",
                             bus.res_sum, bus.res_cout, bus.res_id, e.sum, e.cout, e.id);
                end
            end
        end
    end

    initial begin : main
        int    t0;
        int    s;
        int    r0;
        int    k;
        item_t it;
        logic [W:0] full;

        bus.res_ready = 1'b1;
        rst = 1'b1;
        q0.push_back('{a: 16'h1234, b: 16'h4321, sum: 16'h5555, cout: 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_sum", bus.res_sum, 0);
        chk("rst_res_cout", bus.res_cout, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_no_ready", bus.req0_ready, 0);

        // single op, accepted in the first cycle after reset release
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("accept_after_reset", bus.req0_ready, 1);
        t0 = cyc;
        @(negedge clk);
        chk("add_busy", bus.busy, 1);
        chk("add_res_valid", bus.res_valid, 0);
        chk("add_res_sum_held", bus.res_sum, 0);
        wait_res_valid("single", 20);
        chk("latency", cyc - t0, N + 1);
        wait_idle("single", 50);

        // carry chain and accept spacing on requester 1
        s = gnt_id.size();
        q1.push_back('{a: 16'h0FFF, b: 16'h0001, sum: 16'h1000, cout: 1'b0});
        q1.push_back('{a: 16'hFFFF, b: 16'h0001, sum: 16'h0000, cout: 1'b1});
        wait_idle("carry", 60);
        chk("carry_grants", gnt_id.size() - s, 2);
        if (gnt_id.size() - s == 2) begin
            chk("accept_spacing", gnt_cyc[s+1] - gnt_cyc[s], N + 2);
        end

        // back-pressure: result must hold while res_ready is low
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        q0.push_back('{a: 16'h1111, b: 16'h2222, sum: 16'h3333, cout: 1'b0});
        wait_res_valid("bp", 30);
        q1.push_back('{a: 16'h7FFF, b: 16'h0001, sum: 16'h8000, cout: 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_sum", bus.res_sum, 16'h3333);
            chk("bp_id", bus.res_id, 0);
            chk("bp_no_ready", bus.req1_ready, 0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", bus.res_valid, 0);
        chk("bp_release_ready1", bus.req1_ready, 1);
        wait_idle("bp", 60);

        // leave the pointer favouring req1 so reset must restore it
        q0.push_back('{a: 16'h00FF, b: 16'h0F01, sum: 16'h1000, cout: 1'b0});
        wait_idle("ptr", 60);

        // contention from reset: both valid continuously
        @(posedge clk);
        #1 rst = 1'b1;
        q0.push_back('{a: 16'h0001, b: 16'h0002, sum: 16'h0003, cout: 1'b0});
        q0.push_back('{a: 16'h8888, b: 16'h8888, sum: 16'h1110, cout: 1'b1});
        q1.push_back('{a: 16'hF0F0, b: 16'h0F10, sum: 16'h0000, cout: 1'b1});
        q1.push_back('{a: 16'h9999, b: 16'h1111, sum: 16'hAAAA, cout: 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0_low", bus.req0_ready, 0);
        chk("rst_ready1_low", bus.req1_ready, 0);
        s = gnt_id.size();
        rdy0_cnt = 0;
        rdy1_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle("contention", 100);
        chk("cont_grants", gnt_id.size() - s, 4);
        if (gnt_id.size() - s == 4) begin
            chk("cont_gnt0", gnt_id[s], 0);
            chk("cont_gnt1", gnt_id[s+1], 1);
            chk("cont_gnt2", gnt_id[s+2], 0);
            chk("cont_gnt3", gnt_id[s+3], 1);
        end
        chk("cont_ready0_cycles", rdy0_cnt, 2);
        chk("cont_ready1_cycles", rdy1_cnt, 2);

        // reset in the second ADD cycle discards the op
        s = gnt_id.size();
        q0.push_back('{a: 16'hAAAA, b: 16'h5555, sum: 16'hFFFF, cout: 1'b0});
        k = 0;
        while (gnt_id.size() == s && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_accepted", gnt_id.size() - s, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_res_sum", bus.res_sum, 0);
        chk("midrst_res_cout", bus.res_cout, 0);
        chk("midrst_res_id", bus.res_id, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_no_ready", bus.req0_ready | bus.req1_ready, 0);
        exp_q.delete();
        q1.push_back('{a: 16'h8000, b: 16'h8000, sum: 16'h0000, cout: 1'b1});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_req1_accept", bus.req1_ready, 1);
        wait_idle("midrst", 60);

        // random operands on both ports with random back-pressure
        r0 = n_res;
        for (int i = 0; i < 1000; i++) begin
            it.a = W'($urandom);
            it.b = W'($urandom);
            full = {1'b0, it.a} + {1'b0, it.b};
            it.sum = full[W-1:0];
            it.cout = full[W];
            if ($urandom_range(0, 1) == 0) q0.push_back(it);
            else q1.push_back(it);
        end
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || bus.busy) && k < 30000) begin
            @(posedge clk);
            #1 bus.res_ready = 1'($urandom_range(0, 1));
            k++;
        end
        bus.res_ready = 1'b1;
        chk("random_in_budget", (k < 30000) ? 1 : 0, 1);
        chk("random_result_count", n_res - r0, 1000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
